// File: rtl/bcrypt_output_collector.sv
// Collects one serial result packet from a bcrypt core, repacks it LSB-first
// into bytes and queues them in a 4-entry first-word fall-through FIFO.
module bcrypt_output_collector #(
    parameter int unsigned PKT_BITS = 286,
    parameter int unsigned TIMEOUT  = 63
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       core_empty,
    input  logic       core_dout,
    output logic       core_rd_en,
    input  logic       rd_en,
    output logic       empty,
    output logic [7:0] dout,
    output logic       dout_last,
    output logic       err_overflow,
    output logic       err_timeout
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [8:0]    LAST_IDX  = 9'(PKT_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_START,
        RECV,
        WAIT_EMPTY
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [TW-1:0] wait_cnt;
    logic [8:0]    bit_idx;
    logic [7:0]    asm_byte;
    logic [7:0]    asm_val;
    logic          is_last_bit;
    logic          byte_done;
    logic          push;
    logic          timeout_hit;

    logic [8:0]    mem [0:3];
    logic [8:0]    head;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        core_rd_en  = 1'b0;
        push        = 1'b0;
        timeout_hit = 1'b0;
        // The incoming bit lands at its final position, so a short final
        // byte keeps zeros in its unused upper bits.
        asm_val              = asm_byte;
        asm_val[bit_idx[2:0]] = core_dout;
        is_last_bit          = (bit_idx == LAST_IDX);
        byte_done            = (bit_idx[2:0] == 3'd7) || is_last_bit;

        case (state)
            IDLE: begin
                if (!core_empty && empty) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                core_rd_en = 1'b1;
                state_nxt  = WAIT_START;
            end
            WAIT_START: begin
                if (core_dout) begin
                    state_nxt = RECV;
                end else if (wait_cnt == TIMEOUT_C) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            RECV: begin
                push = byte_done;
                if (is_last_bit) begin
                    state_nxt = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                // Hold until the core drops its pending flag so the same
                // result is never requested twice.
                if (core_empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bit_idx  <= '0;
            asm_byte <= '0;
        end else begin
            wait_cnt <= (state == WAIT_START) ? wait_cnt + 1'b1 : '0;
            bit_idx  <= (state == RECV) ? bit_idx + 9'd1 : 9'd0;
            if (state == RECV) begin
                asm_byte <= byte_done ? 8'h00 : asm_val;
            end else begin
                asm_byte <= 8'h00;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle;
    // otherwise the byte is lost because the core cannot be stalled.
    assign full    = (count == 3'd4);
    assign empty   = (count == 3'd0);
    assign pop     = rd_en && !empty;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'b00, push_ok} - {2'b00, pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr] <= {is_last_bit, asm_val};
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (drop) begin
                err_overflow <= 1'b1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign dout      = empty ? 8'h00 : head[7:0];
    assign dout_last = empty ? 1'b0 : head[8];

endmodule

// File: tb/tb_bcrypt_output_collector.sv
// Bench for bcrypt_output_collector: a core model streams packets, a queue
// model predicts FIFO contents and a monitor checks every downstream pop.
module tb_bcrypt_output_collector;
    localparam int PKT_BITS = 286;
    localparam int TIMEOUT  = 63;
    localparam int NBYTES   = (PKT_BITS + 7) / 8;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       core_empty = 1'b1;
    logic       core_dout = 1'b0;
    logic       core_rd_en;
    logic       rd_en = 1'b0;
    logic       empty;
    logic [7:0] dout;
    logic       dout_last;
    logic       err_overflow;
    logic       err_timeout;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    bit         exp_ovf = 1'b0;
    int         dmode = 1;
    bit         at_byte_end = 1'b0;
    int         pulses = 0;
    int         pops = 0;
    int         lasts = 0;
    bit         first_seen = 1'b0;
    logic [8:0] first_val = '0;
    logic [8:0] last_val = '0;

    always #5 CLK = ~CLK;

    bcrypt_output_collector #(.PKT_BITS(PKT_BITS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .rst_n(rst_n), .core_empty(core_empty), .core_dout(core_dout),
        .core_rd_en(core_rd_en), .rd_en(rd_en), .empty(empty), .dout(dout),
        .dout_last(dout_last), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Downstream driver: 0 = random pops, 1 = never pop, 2 = pop only when full on a push cycle
    initial forever begin
        @(negedge CLK);
        #1;
        case (dmode)
            0: rd_en = ($urandom_range(0, 3) != 0);
            1: rd_en = 1'b0;
            default: rd_en = (exp_q.size() == 4) && at_byte_end;
        endcase
    end

    // Monitor: every pop must match the head of the expected queue
    initial forever begin
        logic [8:0] e;
        @(negedge CLK);
        #2;
        if (core_rd_en) pulses++;
        if (rd_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pop_not_empty", {31'd0, empty}, 32'd0);
                chk("pop_data", {23'd0, dout_last, dout}, {23'd0, e});
                pops++;
                if (dout_last) lasts++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_val  = {dout_last, dout};
                end
                last_val = {dout_last, dout};
            end else begin
                chk("idle_empty", {31'd0, empty}, 32'd1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Core model: waits for the request, sends 0, the marker, then the payload.
    // The expected entry is queued when a byte completes; it is dropped when the
    // modelled FIFO holds four entries after this cycle's pop.
    task automatic send_packet(input int pat, input int rst_at);
        bit         b[PKT_BITS];
        logic [7:0] bytes[NBYTES];
        int         n;
        for (int i = 0; i < PKT_BITS; i++)
            b[i] = (pat == 0) ? ((i % 3) == 0) : 1'($urandom_range(0, 1));
        for (int k = 0; k < NBYTES; k++) begin
            bytes[k] = 8'h00;
            for (int j = 0; j < 8; j++)
                if (8 * k + j < PKT_BITS) bytes[k][j] = b[8 * k + j];
        end
        n = 0;
        while (!core_rd_en && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("core_rd_en_seen", {31'd0, core_rd_en}, 32'd1);
        if (!core_rd_en) return;
        @(negedge CLK); core_dout = 1'b0;
        @(negedge CLK); core_dout = 1'b1;
        for (int i = 0; i < PKT_BITS; i++) begin
            @(negedge CLK);
            core_dout   = b[i];
            at_byte_end = ((i % 8) == 7) || (i == PKT_BITS - 1);
            if (i == rst_at) begin
                rst_n       = 1'b0;
                at_byte_end = 1'b0;
                return;
            end
            #3;
            if (at_byte_end) begin
                if (exp_q.size() < 4) exp_q.push_back({(i == PKT_BITS - 1), bytes[i / 8]});
                else exp_ovf = 1'b1;
            end
        end
        @(negedge CLK);
        core_dout   = 1'b0;
        core_empty  = 1'b1;
        at_byte_end = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        dmode = 0;
        while ((exp_q.size() != 0 || !empty) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0; core_empty = 1'b1; core_dout = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        exp_q.delete();
        exp_ovf = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        // Reset values, with the core already claiming a result
        core_empty = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_dout_last", {31'd0, dout_last}, 32'd0);
        chk("rst_core_rd_en", {31'd0, core_rd_en}, 32'd0);
        chk("rst_err_overflow", {31'd0, err_overflow}, 32'd0);
        chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        core_empty = 1'b1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) @(negedge CLK);
        chk("no_req_when_core_empty", pulses, 0);

        // Single packet with the i%3 pattern
        dmode = 0; pulses = 0; pops = 0; lasts = 0; first_seen = 1'b0;
        core_empty = 1'b0;
        send_packet(0, -1);
        drain("single_drain");
        repeat (5) @(negedge CLK);
        chk("single_pulses", pulses, 1);
        chk("single_bytes", pops, NBYTES);
        chk("single_lasts", lasts, 1);
        chk("single_byte0", {23'd0, first_val}, 32'h049);
        chk("single_byte35", {23'd0, last_val}, 32'h124);
        chk("single_no_ovf", {31'd0, err_overflow}, {31'd0, exp_ovf});

        // Back-to-back random packets, core_empty toggling between them
        pulses = 0; pops = 0; lasts = 0;
        for (int p = 0; p < 2; p++) begin
            repeat (3) @(negedge CLK);
            core_empty = 1'b0;
            send_packet(1, -1);
        end
        drain("b2b_drain");
        repeat (5) @(negedge CLK);
        chk("b2b_pulses", pulses, 2);
        chk("b2b_bytes", pops, 2 * NBYTES);
        chk("b2b_lasts", lasts, 2);
        chk("b2b_ovf", {31'd0, err_overflow}, {31'd0, exp_ovf});

        // Full FIFO: pop only on push cycles while holding four entries
        dmode = 2;
        core_empty = 1'b0;
        send_packet(1, -1);
        repeat (3) @(negedge CLK);
        chk("full_poppush_no_ovf", {31'd0, err_overflow}, 32'd0);
        chk("full_model_count", exp_q.size(), 4);
        pops = 0;
        drain("full_drain");
        chk("full_retained", pops, 4);

        // Overflow: downstream never pops during the packet
        dmode = 1; pops = 0; first_seen = 1'b0;
        core_empty = 1'b0;
        send_packet(0, -1);
        repeat (3) @(negedge CLK);
        chk("ovf_flag", {31'd0, err_overflow}, {31'd0, exp_ovf});
        chk("ovf_flag_set", {31'd0, err_overflow}, 32'd1);
        drain("ovf_drain");
        chk("ovf_retained", pops, 4);
        chk("ovf_first", {23'd0, first_val}, 32'h049);
        repeat (5) @(negedge CLK);
        chk("ovf_sticky", {31'd0, err_overflow}, 32'd1);
        do_reset();
        @(negedge CLK);
        chk("ovf_cleared_by_reset", {31'd0, err_overflow}, 32'd0);

        // Timeout: marker never arrives
        dmode = 0;
        core_empty = 1'b0; core_dout = 1'b0;
        n = 0;
        while (!core_rd_en && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("to_first_req", {31'd0, core_rd_en}, 32'd1);
        repeat (TIMEOUT + 1) @(negedge CLK);
        chk("to_not_yet", {31'd0, err_timeout}, 32'd0);
        @(negedge CLK);
        chk("to_flag", {31'd0, err_timeout}, 32'd1);
        chk("to_idle_no_req", {31'd0, core_rd_en}, 32'd0);
        @(negedge CLK);
        chk("to_second_req", {31'd0, core_rd_en}, 32'd1);
        repeat (10) @(negedge CLK);
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);
        do_reset();
        @(negedge CLK);
        chk("to_cleared_by_reset", {31'd0, err_timeout}, 32'd0);

        // Reset in the middle of the payload, then a clean packet
        dmode = 0; lasts = 0;
        core_empty = 1'b0;
        send_packet(1, 100);
        @(negedge CLK);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_no_req", {31'd0, core_rd_en}, 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        lasts = 0; pops = 0; pulses = 0;
        core_empty = 1'b1; core_dout = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge CLK);
        chk("midrst_no_last", lasts, 0);
        core_empty = 1'b0;
        send_packet(1, -1);
        drain("midrst_drain");
        chk("midrst_bytes", pops, NBYTES);
        chk("midrst_lasts", lasts, 1);
        chk("midrst_pulses", pulses, 1);
        chk("midrst_no_ovf", {31'd0, err_overflow}, {31'd0, exp_ovf});

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
